glob_regfile: RTL

GLOB_REGFILE -- requirements
Module: glob_regfile

---
 rtl/glob_regfile.sv | 117 +++++++++++
 1 files changed

// File: rtl/glob_regfile.sv
// Global parameter/descriptor register file with per-slot dirty tracking.
// Optional shadow checkpoint (save/restore) enabled by defining GLOB_REGFILE_CHECKPOINT_EN.
module glob_regfile #(
    parameter int NPARAM = 5,
    parameter int NDESC  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPARAM-1:0]     param_set,
    input  logic [32*NPARAM-1:0]  param_value,
    input  logic [NDESC-1:0]      desc_set,
    input  logic [64*NDESC-1:0]   desc_value,
    input  logic                  ckpt_save,
    input  logic                  ckpt_restore,
    output logic [32*NPARAM-1:0]  glob_param,
    output logic [64*NDESC-1:0]   glob_descriptor,
    output logic [32*NDESC-1:0]   glob_desc_base,
    output logic [32*NDESC-1:0]   glob_desc_limit,
    output logic [NPARAM+NDESC-1:0] glob_dirty,
    output logic                  ckpt_valid
);
    localparam int NSLOT = NPARAM + NDESC;

    logic [32*NPARAM-1:0] param_q, param_d;
    logic [64*NDESC-1:0]  desc_q, desc_d;
    logic [NSLOT-1:0]     dirty_q, dirty_d;
    logic [NSLOT-1:0]     set_all;
    logic                 restore_eff;

    assign set_all = {desc_set, param_set};

`ifdef GLOB_REGFILE_CHECKPOINT_EN
    logic [32*NPARAM-1:0] shadow_param_q, shadow_param_d;
    logic [64*NDESC-1:0]  shadow_desc_q, shadow_desc_d;
    logic                 valid_q, valid_d;

    // A restore only takes effect once a snapshot exists.
    assign restore_eff = ckpt_restore & valid_q;

    always_comb begin
        shadow_param_d = shadow_param_q;
        shadow_desc_d  = shadow_desc_q;
        valid_d        = valid_q;
        if (ckpt_save && !restore_eff) begin
            shadow_param_d = param_q;
            shadow_desc_d  = desc_q;
            valid_d        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_param_q <= '0;
            shadow_desc_q  <= '0;
            valid_q        <= 1'b0;
        end else begin
            shadow_param_q <= shadow_param_d;
            shadow_desc_q  <= shadow_desc_d;
            valid_q        <= valid_d;
        end
    end

    assign ckpt_valid = valid_q;
`else
    logic unused_restore;
    assign unused_restore = ckpt_restore;
    assign restore_eff    = 1'b0;
    assign ckpt_valid     = 1'b0;
`endif

    always_comb begin
        param_d = param_q;
        desc_d  = desc_q;
        dirty_d = dirty_q;
        if (restore_eff) begin
`ifdef GLOB_REGFILE_CHECKPOINT_EN
            param_d = shadow_param_q;
            desc_d  = shadow_desc_q;
`endif
            dirty_d = '0;
        end else begin
            for (int i = 0; i < NPARAM; i++) begin
                if (param_set[i]) param_d[32*i +: 32] = param_value[32*i +: 32];
            end
            for (int j = 0; j < NDESC; j++) begin
                if (desc_set[j]) desc_d[64*j +: 64] = desc_value[64*j +: 64];
            end
            // Save clears history; only writes landing in the save cycle remain dirty.
            dirty_d = ckpt_save ? set_all : (dirty_q | set_all);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            param_q <= '0;
            desc_q  <= '0;
            dirty_q <= '0;
        end else begin
            param_q <= param_d;
            desc_q  <= desc_d;
            dirty_q <= dirty_d;
        end
    end

    assign glob_param      = param_q;
    assign glob_descriptor = desc_q;
    assign glob_dirty      = dirty_q;

    // Segment-style decode: G bit selects 4 KiB granularity for the limit.
    for (genvar j = 0; j < NDESC; j++) begin : g_desc
        assign glob_desc_base[32*j +: 32] = {desc_q[64*j+56 +: 8], desc_q[64*j+16 +: 24]};
        assign glob_desc_limit[32*j +: 32] = desc_q[64*j+55]
            ? {desc_q[64*j+48 +: 4], desc_q[64*j +: 16], 12'hFFF}
            : {12'd0, desc_q[64*j+48 +: 4], desc_q[64*j +: 16]};
    end

endmodule
